// File: rtl/hough_link_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hough_link_pkg
// Description : Shared definitions for the Hough result link. These include
//               the transmitter state encoding, the frame length, the default
//               framing bytes and the checksum helper used by both ends.
// Revision    : 1.0 - initial release
// ============================================================================
package hough_link_pkg;

  // Transmit sequencer states (explicit 3-bit encoding)
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOAD      = 3'd1,
    SEND      = 3'd2,
    WAIT_ACK  = 3'd3,
    WAIT_DONE = 3'd4
  } tx_state_t;

  // Header + 4 payload bytes + checksum + footer
  localparam int FRAME_LEN = 7;

  localparam logic [7:0] HEADER_DEFAULT = 8'hAA;
  localparam logic [7:0] FOOTER_DEFAULT = 8'h55;

  // Checksum is the XOR of the four payload bytes, in transmit order
  function automatic logic [7:0] frame_chk(input logic [15:0] rho,
                                           input logic [15:0] theta);
    return rho[15:8] ^ rho[7:0] ^ theta[15:8] ^ theta[7:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/hough_result_tx.sv
`default_nettype none
// ============================================================================
// Module      : hough_result_tx
// Description : Serialises each Hough (rho, theta) result into a 7-byte
//               framed, checksummed packet. The packet is handed byte by byte
//               to the UART transmitter over its start/busy handshake. One
//               further result can wait in a pending slot. Anything beyond
//               that is dropped and flagged through the sticky overrun output.
// Revision    : 1.0 - initial release
// ============================================================================
module hough_result_tx
  import hough_link_pkg::*;
#(
  parameter logic [7:0] HEADER      = HEADER_DEFAULT,
  parameter logic [7:0] FOOTER      = FOOTER_DEFAULT,
  parameter int         ACK_TIMEOUT = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        result_valid,
  input  logic [15:0] rho,
  input  logic [15:0] theta,
  input  logic        tx_busy,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  output logic        busy,
  output logic        overrun,
  output logic [7:0]  frame_count
);

  // Counter just wide enough to reach ACK_TIMEOUT-1
  localparam int              C_TO_W     = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [C_TO_W-1:0] C_TO_LAST  = C_TO_W'(ACK_TIMEOUT - 1);
  localparam logic [2:0]      C_LAST_IDX = 3'(FRAME_LEN - 1);

  // Sequencer state
  tx_state_t          r_state;
  tx_state_t          w_state_next;

  // Active frame being transmitted
  logic [15:0]        r_act_rho;
  logic [15:0]        r_act_theta;
  logic [7:0]         r_act_chk;

  // One-deep pending slot
  logic [15:0]        r_pend_rho;
  logic [15:0]        r_pend_theta;
  logic               r_pend_valid;

  // Byte sequencing
  logic [2:0]         r_byte_idx;
  logic [C_TO_W-1:0]  r_to_cnt;
  logic               r_tx_start;
  logic [7:0]         r_tx_data;
  logic               r_overrun;
  logic [7:0]         r_frame_count;

  // Control strobes from the next-state logic
  logic               w_take_pend;
  logic               w_take_input;
  logic               w_idx_clr;
  logic               w_idx_inc;
  logic               w_start_byte;
  logic               w_to_inc;
  logic               w_frame_done;

  // Pending-slot decisions
  logic               w_pend_free;
  logic               w_pend_capture;
  logic               w_drop;

  // Byte currently selected by r_byte_idx
  logic [7:0]         w_frame_byte;

  // Next-state and control strobes for the byte sequencer
  always_comb begin
    w_state_next = r_state;
    w_take_pend  = 1'b0;
    w_take_input = 1'b0;
    w_idx_clr    = 1'b0;
    w_idx_inc    = 1'b0;
    w_start_byte = 1'b0;
    w_to_inc     = 1'b0;
    w_frame_done = 1'b0;
    case (r_state)
      IDLE: begin
        // A waiting result always has priority over a fresh one
        if (r_pend_valid) begin
          w_take_pend  = 1'b1;
          w_state_next = LOAD;
        end else if (result_valid) begin
          w_take_input = 1'b1;
          w_state_next = LOAD;
        end
      end
      LOAD: begin
        w_idx_clr    = 1'b1;
        w_state_next = SEND;
      end
      SEND: begin
        if (!tx_busy) begin
          w_start_byte = 1'b1;
          w_state_next = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        // A UART that never raises busy must not stall the link forever
        if (tx_busy) begin
          w_state_next = WAIT_DONE;
        end else if (r_to_cnt == C_TO_LAST) begin
          w_state_next = WAIT_DONE;
        end else begin
          w_to_inc = 1'b1;
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          if (r_byte_idx == C_LAST_IDX) begin
            w_frame_done = 1'b1;
            w_state_next = IDLE;
          end else begin
            w_idx_inc    = 1'b1;
            w_state_next = SEND;
          end
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // Route a new result that is not going straight into the active frame
  always_comb begin
    w_pend_free    = ~r_pend_valid | w_take_pend;
    w_pend_capture = result_valid & ~w_take_input & w_pend_free;
    w_drop         = result_valid & ~w_take_input & ~w_pend_free;
  end

  // Frame byte selector
  always_comb begin
    w_frame_byte = HEADER;
    case (r_byte_idx)
      3'd0:    w_frame_byte = HEADER;
      3'd1:    w_frame_byte = r_act_rho[15:8];
      3'd2:    w_frame_byte = r_act_rho[7:0];
      3'd3:    w_frame_byte = r_act_theta[15:8];
      3'd4:    w_frame_byte = r_act_theta[7:0];
      3'd5:    w_frame_byte = r_act_chk;
      3'd6:    w_frame_byte = FOOTER;
      default: w_frame_byte = HEADER;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Active frame and pending slot capture, overrun flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_act_rho    <= 16'h0000;
      r_act_theta  <= 16'h0000;
      r_act_chk    <= 8'h00;
      r_pend_rho   <= 16'h0000;
      r_pend_theta <= 16'h0000;
      r_pend_valid <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      // Checksum is fixed when the values enter the active frame
      if (w_take_pend) begin
        r_act_rho   <= r_pend_rho;
        r_act_theta <= r_pend_theta;
        r_act_chk   <= frame_chk(r_pend_rho, r_pend_theta);
      end else if (w_take_input) begin
        r_act_rho   <= rho;
        r_act_theta <= theta;
        r_act_chk   <= frame_chk(rho, theta);
      end

      if (w_pend_capture) begin
        r_pend_rho   <= rho;
        r_pend_theta <= theta;
      end

      if (w_pend_capture) begin
        r_pend_valid <= 1'b1;
      end else if (w_take_pend) begin
        r_pend_valid <= 1'b0;
      end

      if (w_drop) begin
        r_overrun <= 1'b1;
      end
    end
  end

  // Byte index, ack timeout counter, UART strobe/data and frame counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_byte_idx    <= 3'd0;
      r_to_cnt      <= '0;
      r_tx_start    <= 1'b0;
      r_tx_data     <= 8'h00;
      r_frame_count <= 8'h00;
    end else begin
      r_tx_start <= w_start_byte;
      // tx_data holds between strobes so the UART may latch it late
      if (w_start_byte) begin
        r_tx_data <= w_frame_byte;
      end

      if (w_idx_clr) begin
        r_byte_idx <= 3'd0;
      end else if (w_idx_inc) begin
        r_byte_idx <= r_byte_idx + 3'd1;
      end

      if (w_start_byte) begin
        r_to_cnt <= '0;
      end else if (w_to_inc) begin
        r_to_cnt <= r_to_cnt + 1'b1;
      end

      if (w_frame_done) begin
        r_frame_count <= r_frame_count + 8'd1;
      end
    end
  end

  assign tx_start    = r_tx_start;
  assign tx_data     = r_tx_data;
  assign busy        = (r_state != IDLE) | r_pend_valid;
  assign overrun     = r_overrun;
  assign frame_count = r_frame_count;

endmodule
`default_nettype wire

// File: tb/tb_hough_result_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_hough_result_tx
// Description : Self-checking bench for hough_result_tx with a UART TX model,
//               directed frame vectors and a randomized scoreboard phase.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hough_result_tx;

  logic        clk = 1'b0;
  logic        reset;
  logic        result_valid;
  logic [15:0] rho;
  logic [15:0] theta;
  logic        tx_busy;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        busy;
  logic        overrun;
  logic [7:0]  frame_count;

  hough_result_tx dut (
    .clk          (clk),
    .reset        (reset),
    .result_valid (result_valid),
    .rho          (rho),
    .theta        (theta),
    .tx_busy      (tx_busy),
    .tx_start     (tx_start),
    .tx_data      (tx_data),
    .busy         (busy),
    .overrun      (overrun),
    .frame_count  (frame_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] rho;
    logic [15:0] theta;
    logic [7:0]  chk;
  } vec_t;

  vec_t        tbl [6];
  int          n_checks = 0;
  int          n_pass   = 0;

  // Observed UART traffic (owned by the TX model process)
  logic [7:0]  got [$];
  int          start_cyc [$];
  int          cyc = 0;
  int          since_start = 0;
  int          starts_total = 0;
  int          b2b_err = 0;
  int          busy_err = 0;
  bit          prev_start = 1'b0;
  bit          busy_prev;
  int          tx_arm = 0;
  int          tx_left = 0;
  int          tx_blen = 10;
  int          tx_dly;

  // Controls for the TX model (owned by the main process)
  int          tx_mode = 0;      // 0: responds with busy, 1: never busy
  bit          rand_lat = 1'b0;

  logic [7:0]  exp_q [$];

  // UART TX model and byte monitor
  initial begin
    tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      busy_prev = tx_busy;
      if (reset === 1'b1) begin
        tx_busy = 1'b0;
        tx_arm  = 0;
        tx_left = 0;
      end else if (tx_busy) begin
        tx_left--;
        if (tx_left <= 0) tx_busy = 1'b0;
      end else if (tx_arm > 0) begin
        tx_arm--;
        if (tx_arm == 0) begin
          tx_busy = 1'b1;
          tx_left = tx_blen;
        end
      end
      if (tx_start === 1'b1) begin
        got.push_back(tx_data);
        start_cyc.push_back(cyc);
        starts_total++;
        since_start = 0;
        if (prev_start) b2b_err++;
        if (busy_prev) busy_err++;
        if (reset !== 1'b1 && tx_mode == 0) begin
          tx_dly  = rand_lat ? int'($urandom_range(0, 2)) : 0;
          tx_blen = rand_lat ? int'($urandom_range(1, 6)) : 10;
          if (tx_dly == 0) begin
            tx_busy = 1'b1;
            tx_left = tx_blen;
          end else begin
            tx_arm = tx_dly;
          end
        end
      end else begin
        since_start++;
      end
      prev_start = (tx_start === 1'b1);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic pulse(input logic [15:0] r, input logic [15:0] t);
    rho = r;
    theta = t;
    result_valid = 1'b1;
    tick();
    result_valid = 1'b0;
  endtask

  task automatic wait_bytes(input int base, input int n, input string name);
    int k = 0;
    while ((got.size() - base) < n && k < 3000) begin
      tick();
      k++;
    end
    check({name, " bytes arrived"}, 32'((got.size() - base) >= n), 32'd1);
  endtask

  task automatic wait_idle(input string name);
    int k = 0;
    while (busy !== 1'b0 && k < 500) begin
      tick();
      k++;
    end
    check({name, " busy low"}, 32'(busy), 32'd0);
  endtask

  task automatic check_frame(input int idx, input logic [15:0] r, input logic [15:0] t,
                             input logic [7:0] chk, input string name);
    logic [7:0] e [7];
    e = '{8'hAA, r[15:8], r[7:0], t[15:8], t[7:0], chk, 8'h55};
    for (int i = 0; i < 7; i++)
      check($sformatf("%s byte%0d", name, i), 32'(got[idx + i]), 32'(e[i]));
  endtask

  task automatic check_reset_vals(input string name);
    check({name, " tx_start"},    32'(tx_start),    32'd0);
    check({name, " tx_data"},     32'(tx_data),     32'd0);
    check({name, " busy"},        32'(busy),        32'd0);
    check({name, " overrun"},     32'(overrun),     32'd0);
    check({name, " frame_count"}, 32'(frame_count), 32'd0);
  endtask

  // Random results against a capacity-of-two scoreboard
  task automatic run_random();
    int          base;
    int          s_base;
    int          accepted;
    int          s;
    int          settled;
    int          n_out;
    bit          amb;
    bit          exp_ovr;
    logic [15:0] r;
    logic [15:0] t;
    int          issued;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    rand_lat = 1'b1;
    tx_mode  = 0;
    base     = got.size();
    s_base   = starts_total;
    accepted = 0;
    exp_ovr  = 1'b0;
    issued   = 0;
    exp_q.delete();
    for (int cy = 0; cy < 20000 && issued < 60; cy++) begin
      s   = starts_total - s_base;
      // Just after a frame's last byte the DUT may or may not have freed a slot
      amb = (s % 7 == 0) && (s > 0) && (since_start < 12);
      settled = amb ? (s / 7) - 1 : (s / 7);
      n_out   = accepted - settled;
      if ($urandom_range(0, 15) == 0 && !(amb && n_out >= 2)) begin
        r = 16'($urandom);
        t = 16'($urandom);
        if (n_out < 2) begin
          exp_q.push_back(8'hAA);
          exp_q.push_back(r[15:8]);
          exp_q.push_back(r[7:0]);
          exp_q.push_back(t[15:8]);
          exp_q.push_back(t[7:0]);
          exp_q.push_back(r[15:8] ^ r[7:0] ^ t[15:8] ^ t[7:0]);
          exp_q.push_back(8'h55);
          accepted++;
        end else begin
          exp_ovr = 1'b1;
        end
        issued++;
        rho = r;
        theta = t;
        result_valid = 1'b1;
      end
      tick();
      result_valid = 1'b0;
    end
    wait_bytes(base, accepted * 7, "rand");
    wait_idle("rand");
    repeat (20) tick();
    check("rand byte total", 32'(got.size() - base), 32'(accepted * 7));
    for (int i = 0; i < exp_q.size(); i++)
      check($sformatf("rand byte%0d", i), 32'(got[base + i]), 32'(exp_q[i]));
    check("rand frame_count", 32'(frame_count), 32'(accepted[7:0]));
    check("rand overrun", 32'(overrun), 32'(exp_ovr));
    rand_lat = 1'b0;
  endtask

  initial begin
    int base;
    int fc_exp;
    tbl[0] = '{16'h0123, 16'h002D, 8'h0F};
    tbl[1] = '{16'hFFFF, 16'h00B3, 8'hB3};
    tbl[2] = '{16'h0010, 16'h0020, 8'h30};
    tbl[3] = '{16'h0000, 16'h0000, 8'h00};
    tbl[4] = '{16'hA5A5, 16'h5A5A, 8'h00};
    tbl[5] = '{16'h8001, 16'h0240, 8'hC3};

    reset = 1'b1;
    result_valid = 1'b0;
    rho = 16'h0000;
    theta = 16'h0000;
    tick();
    tick();
    check_reset_vals("reset");
    reset = 1'b0;
    tick();

    // Single frames from the vector table, including first-byte latency
    fc_exp = 0;
    for (int i = 0; i < 6; i++) begin
      base = got.size();
      rho = tbl[i].rho;
      theta = tbl[i].theta;
      result_valid = 1'b1;
      tick();
      result_valid = 1'b0;
      tick();
      check($sformatf("vec%0d no early start", i), 32'(tx_start), 32'd0);
      tick();
      check($sformatf("vec%0d start latency", i), 32'(tx_start), 32'd1);
      check($sformatf("vec%0d first data", i), 32'(tx_data), 32'hAA);
      wait_bytes(base, 7, $sformatf("vec%0d", i));
      wait_idle($sformatf("vec%0d", i));
      check_frame(base, tbl[i].rho, tbl[i].theta, tbl[i].chk, $sformatf("vec%0d", i));
      fc_exp++;
      check($sformatf("vec%0d frame_count", i), 32'(frame_count), 32'(fc_exp));
      check($sformatf("vec%0d overrun", i), 32'(overrun), 32'd0);
      check($sformatf("vec%0d byte total", i), 32'(got.size() - base), 32'd7);
    end

    // Back-to-back: second result arrives mid-frame
    base = got.size();
    pulse(16'h0123, 16'h002D);
    wait_bytes(base, 2, "b2b first");
    pulse(16'h0010, 16'h0020);
    wait_bytes(base, 14, "b2b");
    wait_idle("b2b");
    check_frame(base, 16'h0123, 16'h002D, 8'h0F, "b2b f1");
    check_frame(base + 7, 16'h0010, 16'h0020, 8'h30, "b2b f2");
    fc_exp += 2;
    check("b2b frame_count", 32'(frame_count), 32'(fc_exp));
    check("b2b overrun", 32'(overrun), 32'd0);

    // Overrun: third result within the first frame is dropped
    base = got.size();
    pulse(16'h1234, 16'h5678);
    wait_bytes(base, 1, "ovr a");
    pulse(16'hABCD, 16'hEF01);
    wait_bytes(base, 2, "ovr b");
    pulse(16'h0F0F, 16'hF0F0);
    wait_bytes(base, 14, "ovr");
    wait_idle("ovr");
    repeat (20) tick();
    check_frame(base, 16'h1234, 16'h5678, 8'h08, "ovr f1");
    check_frame(base + 7, 16'hABCD, 16'hEF01, 8'h88, "ovr f2");
    check("ovr byte total", 32'(got.size() - base), 32'd14);
    fc_exp += 2;
    check("ovr frame_count", 32'(frame_count), 32'(fc_exp));
    check("ovr overrun set", 32'(overrun), 32'd1);
    repeat (30) tick();
    check("ovr overrun sticky", 32'(overrun), 32'd1);

    // Ack timeout: UART never raises busy
    tx_mode = 1;
    base = got.size();
    pulse(16'h0123, 16'h002D);
    wait_bytes(base, 7, "ack_to");
    wait_idle("ack_to");
    check_frame(base, 16'h0123, 16'h002D, 8'h0F, "ack_to");
    for (int i = 1; i < 7; i++)
      check($sformatf("ack_to gap%0d", i),
            32'(start_cyc[base + i] - start_cyc[base + i - 1]), 32'd10);
    fc_exp++;
    check("ack_to frame_count", 32'(frame_count), 32'(fc_exp));
    check("ack_to overrun", 32'(overrun), 32'd1);
    tx_mode = 0;
    repeat (5) tick();

    // Reset mid-frame with a result pending
    base = got.size();
    pulse(16'h0123, 16'h002D);
    wait_bytes(base, 1, "rst a");
    pulse(16'h4444, 16'h5555);
    wait_bytes(base, 3, "rst b");
    reset = 1'b1;
    #1;
    check_reset_vals("mid-frame reset");
    tick();
    reset = 1'b0;
    tick();
    base = got.size();
    pulse(16'h0F0F, 16'hF0F0);
    wait_bytes(base, 7, "post-rst");
    wait_idle("post-rst");
    repeat (30) tick();
    check("post-rst byte total", 32'(got.size() - base), 32'd7);
    check_frame(base, 16'h0F0F, 16'hF0F0, 8'h00, "post-rst");
    check("post-rst frame_count", 32'(frame_count), 32'd1);

    run_random();

    check("no back-to-back tx_start", 32'(b2b_err), 32'd0);
    check("no tx_start while tx_busy", 32'(busy_err), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
